// File: rtl/acc_pkg.sv
// acc_pkg: shared definitions for the accumulator register bank.
//   state_e  - two-state frame FSM encoding (COLLECT / HOLD)
//   sat_max  - most positive W-bit signed value, returned in 64 bits
//   sat_min  - most negative W-bit signed value, returned in 64 bits
// Callers slice the low W bits of sat_max/sat_min to get the clamp constants.
package acc_pkg;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_e;

    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/sat_adder.sv
// sat_adder: combinational W-bit signed adder with overflow detect.
//   a, b  - signed operands
//   sum   - a+b, clamped to MAX/MIN when SAT=1, wrapped modulo 2^W when SAT=0
//   ovf   - signed overflow of a+b, reported in both modes
module sat_adder
    import acc_pkg::*;
#(
    parameter int W   = 21,
    parameter int SAT = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    localparam logic [63:0]  MAX64 = sat_max(W);
    localparam logic [63:0]  MIN64 = sat_min(W);
    localparam logic [W-1:0] MAX_V = MAX64[W-1:0];
    localparam logic [W-1:0] MIN_V = MIN64[W-1:0];

    logic [W-1:0] raw;

    always_comb begin
        raw = a + b;
        // Overflow only when both operands share a sign and the result flips it.
        ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
        sum = raw;
        if (SAT != 0 && ovf) begin
            sum = a[W-1] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/acc_register_bank.sv
// acc_register_bank: CH independent signed accumulators. Each frame is DEPTH
// accepted input beats; the first beat loads, later beats add (saturate or
// wrap). After the last beat the result is held until downstream takes it.
//   clk, rst (async, active-low)  clear (sync frame abort, highest priority)
//   in_valid/in_ready/in_data     - beat input, channel c at [c*W +: W]
//   out_valid/out_ready/out_data  - result frame, same packing
//   ovf                           - per-channel sticky overflow for the frame
module acc_register_bank
    import acc_pkg::*;
#(
    parameter int W     = 21,
    parameter int CH    = 4,
    parameter int DEPTH = 8,
    parameter int SAT   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CH*W-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CH*W-1:0] out_data,
    output logic [CH-1:0]   ovf
);

    localparam int          CW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [CH-1:0][W-1:0]    acc_q, acc_d;
    logic [CH-1:0]           ovf_q, ovf_d;
    logic [CH-1:0][W-1:0]    sum;
    logic [CH-1:0]           add_ovf;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        sat_adder #(.W(W), .SAT(SAT)) u_add (
            .a   (acc_q[c]),
            .b   (in_data[c*W +: W]),
            .sum (sum[c]),
            .ovf (add_ovf[c])
        );
    end

    // Handshake outputs decode straight from the state flop, so there is no
    // combinational path from in_valid to out_valid.
    assign in_ready  = (state_q == ST_COLLECT);
    assign out_valid = (state_q == ST_HOLD);
    assign out_data  = acc_q;
    assign ovf       = ovf_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = ST_COLLECT;
            cnt_d   = '0;
            acc_d   = '0;
            ovf_d   = '0;
        end else if (state_q == ST_COLLECT) begin
            if (in_valid) begin
                if (cnt_q == '0) begin
                    acc_d = in_data;
                    ovf_d = '0;
                end else begin
                    acc_d = sum;
                    ovf_d = ovf_q | add_ovf;
                end
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end else if (out_ready) begin
            state_d = ST_COLLECT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_COLLECT;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_acc_register_bank.sv
module tb_acc_register_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_data = '0;

    // s_* : saturating instance, w_* : wrapping instance, same stimulus
    logic        s_in_ready, s_out_valid, w_in_ready, w_out_valid;
    logic [15:0] s_out_data, w_out_data;
    logic [1:0]  s_ovf, w_ovf;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    acc_register_bank #(.W(8), .CH(2), .DEPTH(4), .SAT(1)) dut_s (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .in_ready(s_in_ready), .in_data(in_data), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_data(s_out_data), .ovf(s_ovf)
    );

    acc_register_bank #(.W(8), .CH(2), .DEPTH(4), .SAT(0)) dut_w (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .in_ready(w_in_ready), .in_data(in_data), .out_valid(w_out_valid),
        .out_ready(out_ready), .out_data(w_out_data), .ovf(w_ovf)
    );

    // Drive one beat for one clock, sample #1 after the edge.
    task automatic beat(input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = {b, a};
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1 || s_ovf !== 2'b00 || s_out_data !== 16'h0000) begin
            failures++;
            $display("FAIL reset_state: ov=%b ir=%b ovf=%b data=%h, want 0 1 00 0000", s_out_valid, s_in_ready, s_ovf, s_out_data);
        end
        @(negedge clk); rst = 1'b1;
        cyc();
        // reach HOLD with ovf[0] set, then reset asynchronously mid-HOLD
        beat(8'd100, 8'd0); beat(8'd100, 8'd0); beat(8'd1, 8'd0); beat(8'd1, 8'd0);
        checks++;
        if (s_out_valid !== 1'b1 || s_ovf !== 2'b01) begin
            failures++;
            $display("FAIL reset_prehold: ov=%b ovf=%b, want 1 01", s_out_valid, s_ovf);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (s_out_valid !== 1'b0 || s_ovf !== 2'b00 || s_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_async: ov=%b ovf=%b ir=%b, want 0 00 1", s_out_valid, s_ovf, s_in_ready);
        end
        @(negedge clk); rst = 1'b1;
        cyc();
        checks++;
        if (s_in_ready !== 1'b1 || s_out_data !== 16'h0000 || s_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: ir=%b data=%h ov=%b, want 1 0000 0", s_in_ready, s_out_data, s_out_valid);
        end
    endtask

    task automatic test_frame();
        beat(8'd1, 8'hF6); beat(8'd2, 8'd5); beat(8'd3, 8'hFD);
        checks++;
        if (s_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL frame_early: out_valid=%b, want 0", s_out_valid);
        end
        beat(8'd4, 8'd1);
        checks++;
        if (s_out_valid !== 1'b1 || s_out_data !== 16'hF90A || s_ovf !== 2'b00) begin
            failures++;
            $display("FAIL frame_result: ov=%b data=%h ovf=%b, want 1 f90a 00", s_out_valid, s_out_data, s_ovf);
        end
        out_ready = 1'b1; cyc(); out_ready = 1'b0;
        checks++;
        if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL frame_drain: ov=%b ir=%b, want 0 1", s_out_valid, s_in_ready);
        end
    endtask

    task automatic test_saturation();
        beat(8'd100, 8'd0); beat(8'd100, 8'd0);
        checks++;
        if (s_out_data[7:0] !== 8'd127 || s_ovf !== 2'b01) begin
            failures++;
            $display("FAIL sat_clamp: ch0=%0d ovf=%b, want 127 01", $signed(s_out_data[7:0]), s_ovf);
        end
        checks++;
        if (w_out_data[7:0] !== 8'hC8 || w_ovf !== 2'b01) begin
            failures++;
            $display("FAIL wrap_add: ch0=%0d ovf=%b, want -56 01", $signed(w_out_data[7:0]), w_ovf);
        end
        beat(8'hCE, 8'd0);
        checks++;
        if (s_out_data[7:0] !== 8'd77 || w_out_data[7:0] !== 8'h96) begin
            failures++;
            $display("FAIL sat_beat3: sat=%0d wrap=%0d, want 77 -106", $signed(s_out_data[7:0]), $signed(w_out_data[7:0]));
        end
        beat(8'd1, 8'd0);
        checks++;
        if (s_out_valid !== 1'b1 || s_out_data !== 16'h004E || s_ovf !== 2'b01) begin
            failures++;
            $display("FAIL sat_final: ov=%b data=%h ovf=%b, want 1 004e 01", s_out_valid, s_out_data, s_ovf);
        end
        checks++;
        if (w_out_data !== 16'h0097 || w_ovf !== 2'b01) begin
            failures++;
            $display("FAIL wrap_final: data=%h ovf=%b, want 0097 01", w_out_data, w_ovf);
        end
        out_ready = 1'b1; cyc(); out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) beat(8'd1, 8'd2);
        in_valid = 1'b1;
        in_data  = {8'd60, 8'd50};
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++;
            if (s_out_valid !== 1'b1 || s_in_ready !== 1'b0 || s_out_data !== 16'h0804) begin
                failures++;
                $display("FAIL bp_hold[%0d]: ov=%b ir=%b data=%h, want 1 0 0804", i, s_out_valid, s_in_ready, s_out_data);
            end
        end
        out_ready = 1'b1; cyc(); out_ready = 1'b0;
        cyc();
        in_valid = 1'b0;
        checks++;
        if (s_out_valid !== 1'b0 || s_out_data !== 16'h3C32 || s_ovf !== 2'b00) begin
            failures++;
            $display("FAIL bp_nextload: ov=%b data=%h ovf=%b, want 0 3c32 00", s_out_valid, s_out_data, s_ovf);
        end
        // finish that frame (3 more beats) and drain it
        for (int i = 0; i < 3; i++) beat(8'd0, 8'd0);
        checks++;
        if (s_out_valid !== 1'b1 || s_out_data !== 16'h3C32) begin
            failures++;
            $display("FAIL bp_frame2: ov=%b data=%h, want 1 3c32", s_out_valid, s_out_data);
        end
        out_ready = 1'b1; cyc(); out_ready = 1'b0;
    endtask

    task automatic test_clear();
        beat(8'd7, 8'd7); beat(8'd7, 8'd7);
        clear = 1'b1; in_valid = 1'b1; in_data = {8'd9, 8'd9};
        cyc();
        clear = 1'b0; in_valid = 1'b0;
        checks++;
        if (s_out_data !== 16'h0000 || s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL clear_mid: data=%h ov=%b ir=%b, want 0000 0 1", s_out_data, s_out_valid, s_in_ready);
        end
        for (int i = 0; i < 3; i++) beat(8'd1, 8'd1);
        checks++;
        if (s_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL clear_cnt: out_valid=%b after 3 beats, want 0", s_out_valid);
        end
        beat(8'd1, 8'd1);
        checks++;
        if (s_out_valid !== 1'b1 || s_out_data[7:0] !== 8'd4) begin
            failures++;
            $display("FAIL clear_refill: ov=%b ch0=%0d, want 1 4", s_out_valid, s_out_data[7:0]);
        end
    endtask

    task automatic test_clear_hold();
        // still in HOLD from test_clear
        clear = 1'b1; out_ready = 1'b1;
        cyc();
        clear = 1'b0; out_ready = 1'b0;
        checks++;
        if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1 || s_out_data !== 16'h0000 || s_ovf !== 2'b00) begin
            failures++;
            $display("FAIL clear_hold: ov=%b ir=%b data=%h ovf=%b, want 0 1 0000 00", s_out_valid, s_in_ready, s_out_data, s_ovf);
        end
        cyc(); cyc();
        checks++;
        if (s_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL clear_dup: out_valid=%b, want 0", s_out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_saturation();
        test_backpressure();
        test_clear();
        test_clear_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
